imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It accepts one instruction plus its PC per valid/ready handshake and emits the sign-extended immediate, a format tag, an illegal-opcode flag and a precomputed PC-relative target. It adds XLEN generalisation (RV32/RV64), CSR zimm support and a 2-entry skid buffer for backpressure. It sits between the fetch/IF-ID register and the register-read/ALU operand mux.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; all immediates sign-extend to XLEN.
EN_TARGET, 1, when 1 compute out_target = pc + imm; when 0 tie out_target to 0.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
flush  in  1  synchronous pipeline kill; clears all buffered entries.
in_valid  in  1  instruction present.
in_ready  out  1  block can accept this cycle.
in_inst  in  32  raw instruction word.
in_pc  in  XLEN  PC of in_inst.
out_valid  out  1  output entry valid.
out_ready  in  1  consumer accepts this cycle.
out_imm  out  XLEN  sign-extended immediate (zimm is zero-extended).
out_type  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
out_illegal  out  1  opcode not recognised.
out_target  out  XLEN  pc+imm for B, J, AUIPC; else 0.
out_pc  out  XLEN  registered in_pc.

Behaviour:
- Reset (async, active-high): out_valid=0, in_ready=1, skid empty; out_imm, out_type, out_illegal, out_target and out_pc all 0.
- Decode (combinational, on in_inst; opcode = inst[6:0]):
  - I-type, for opcodes 0010011, 0000011, 1100111, 0001111: imm = sext(inst[31:20]).
  - S-type, opcode 0100011: imm = sext({inst[31:25], inst[11:7]}).
  - B-type, opcode 1100011: imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U-type, opcodes 0110111 and 0010111: imm = sext({inst[31:12], 12'b0}). On XLEN=64, bit 31 is replicated.
  - J-type, opcode 1101111: imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - SYSTEM, opcode 1110011:
    - funct3 in {101, 110, 111}: type Z, imm = zext(inst[19:15]).
    - funct3 in {001, 010, 011}: type I, imm = sext(inst[31:20]).
    - funct3 000 or 100: type NONE, imm 0.
  - R-type, opcode 0110011: type NONE, imm 0, legal.
  - Any other opcode, or inst[1:0] != 2'b11: type NONE, imm 0, illegal = 1.
- Target: pc + imm, modulo 2^XLEN (wrap, no flag), for B, J and AUIPC only. LUI, JALR and all other opcodes give 0.
- Latency: exactly 1 cycle from accept (in_valid && in_ready) to out_valid, when the output stage is empty or draining.
- Skid buffer: one main output register plus one skid register.
  - in_ready = !skid_full, registered.
  - Accept while main is empty, or while out_ready=1 is popping it: the entry loads main.
  - Accept while main is held (out_valid=1, out_ready=0): the entry loads skid, and in_ready falls the next cycle.
  - On a pop with skid full: skid moves to main the same cycle; skid empties and in_ready rises the next cycle.
  - Ordering is strictly FIFO; no entry is dropped or duplicated.
  - Simultaneous accept and pop with skid full is impossible, because in_ready=0.
- Output stability: while out_valid=1 and out_ready=0, all out_* are held stable.
- flush: has priority over accept and pop. The next cycle gives out_valid=0, skid empty, in_ready=1. An in_valid asserted in the flush cycle is discarded.
- rst mid-stream: all entries are lost immediately and the block comes up in the reset state above.

Test Plan:
- XLEN=32, inst 0xFFF00093 (addi x1,x0,-1), pc 0x0, out_ready=1 -> one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_type=1, out_illegal=0, out_target=0.
- inst 0xFE000EE3 (beq -4), pc 0x100 -> out_imm=0xFFFFFFFC, out_type=3, out_target=0x000000FC. Then inst 0x001000EF (jal x1,+2048), pc 0x1000 -> out_imm=0x800, out_type=5, out_target=0x1800.
- inst 0x3002D073 (csrrwi x0,mstatus,5) -> out_imm=0x5, out_type=6. Then inst 0x0000007F -> out_illegal=1, out_type=0, out_imm=0.
- XLEN=64, inst 0x80000537 (lui x10,0x80000) -> out_imm=0xFFFFFFFF80000000, out_type=4, out_target=0.
- Backpressure: stream A, B, C back-to-back with out_ready=0 -> A in main, B in skid, in_ready=0 and C not accepted. Raise out_ready -> A, B, C appear in order, outputs stable while stalled, no loss or duplication.
- Buffers full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, the flushed entry never appears. Also assert rst asynchronously mid-stream -> out_valid drops immediately.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Registered immediate generator for the decode stage. Each accepted
// instruction is decoded into a sign-extended immediate (zero-extended for
// CSR zimm), a format tag, an illegal-opcode flag and a PC-relative target.
// Results leave through a two-deep output stage (main register + skid
// register) so the upstream handshake can run at full rate under
// backpressure.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous kill of every buffered entry
//   in_valid/ready  input handshake; in_ready is a flop (= skid empty)
//   in_inst, in_pc  instruction word and its PC
//   out_valid/ready output handshake
//   out_imm         XLEN-bit immediate
//   out_type        0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_illegal     opcode not recognised
//   out_target      pc + imm for B, J and AUIPC, otherwise 0
//   out_pc          PC of the entry being presented
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter bit EN_TARGET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            ill;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_ill;
  logic            dec_use_tgt;
  logic [XLEN-1:0] dec_tgt;
  entry_t          dec_entry;

  entry_t main_q, skid_q;
  logic   main_valid, skid_full;
  logic   accept;

  // Immediate extraction. Each concatenation is exactly XLEN bits wide; the
  // sign bit of every format is inst[31], so replication widths stay positive
  // for both XLEN=32 and XLEN=64.
  always_comb begin
    dec_imm     = '0;
    dec_type    = T_NONE;
    dec_ill     = 1'b0;
    dec_use_tgt = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (in_inst[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
          dec_type = T_I;
          dec_imm  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
        end
        7'b0100011: begin
          dec_type = T_S;
          dec_imm  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        end
        7'b1100011: begin
          dec_type    = T_B;
          dec_use_tgt = 1'b1;
          dec_imm     = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25],
                         in_inst[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec_type    = T_U;
          dec_use_tgt = in_inst[5] == 1'b0;  // AUIPC only, LUI has no target
          dec_imm     = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
        end
        7'b1101111: begin
          dec_type    = T_J;
          dec_use_tgt = 1'b1;
          dec_imm     = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20],
                         in_inst[30:21], 1'b0};
        end
        7'b1110011: begin
          case (in_inst[14:12])
            3'b101, 3'b110, 3'b111: begin
              dec_type = T_Z;
              dec_imm  = {{(XLEN-5){1'b0}}, in_inst[19:15]};
            end
            3'b001, 3'b010, 3'b011: begin
              dec_type = T_I;
              dec_imm  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            end
            default: ;  // ECALL/EBREAK/xRET and reserved funct3: no immediate
          endcase
        end
        7'b0110011: ;  // R-type: legal, no immediate
        default: dec_ill = 1'b1;
      endcase
    end
  end

  assign dec_tgt   = (EN_TARGET && dec_use_tgt) ? (in_pc + dec_imm) : '0;
  assign dec_entry = '{imm: dec_imm, typ: dec_type, ill: dec_ill,
                       tgt: dec_tgt, pc: in_pc};

  assign accept = in_valid && !skid_full;

  // skid_full implies main_valid, so whenever main is free or draining the
  // skid (if occupied) refills main and no accept can coincide with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_full) begin
        main_q    <= skid_q;
        skid_full <= 1'b0;
      end else if (accept) begin
        main_q     <= dec_entry;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q    <= dec_entry;
      skid_full <= 1'b1;
    end
  end

  assign in_ready    = !skid_full;
  assign out_valid   = main_valid;
  assign out_imm     = main_q.imm;
  assign out_type    = main_q.typ;
  assign out_illegal = main_q.ill;
  assign out_target  = main_q.tgt;
  assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [31:0] pc32;
  logic [63:0] pc64;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, tgt32, opc32;
  logic [2:0]  typ32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64, tgt64, opc64;
  logic [2:0]  typ64;

  imm_gen_pipe #(.XLEN(32), .EN_TARGET(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_pc(pc32), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_type(typ32), .out_illegal(ill32),
    .out_target(tgt32), .out_pc(opc32));

  imm_gen_pipe #(.XLEN(64), .EN_TARGET(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_pc(pc64), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_type(typ64), .out_illegal(ill64),
    .out_target(tgt64), .out_pc(opc64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
    logic [63:0] tgt;
    logic [63:0] pc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode: immediates built as signed integers from the field
  // layout, then reduced modulo 2^xlen.
  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc,
                                 input int xlen);
    exp_t        e;
    longint      v;
    bit          tg;
    logic [63:0] mask;
    mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    v     = 0;
    tg    = 0;
    e.typ = 3'd0;
    e.ill = 1'b0;
    if (inst[1:0] != 2'b11) e.ill = 1'b1;
    else begin
      case (inst[6:0])
        7'h13, 7'h03, 7'h67, 7'h0F: begin
          e.typ = 3'd1;
          v = longint'(inst[31:20]);
          if (v >= 2048) v -= 4096;
        end
        7'h23: begin
          e.typ = 3'd2;
          v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
          if (v >= 2048) v -= 4096;
        end
        7'h63: begin
          e.typ = 3'd3; tg = 1;
          v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
              longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
          if (v >= 4096) v -= 8192;
        end
        7'h37, 7'h17: begin
          e.typ = 3'd4; tg = (inst[6:0] == 7'h17);
          v = longint'(inst[31:12]) * 4096;
          if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
        end
        7'h6F: begin
          e.typ = 3'd5; tg = 1;
          v = longint'(inst[31]) * (1 << 20) + longint'(inst[19:12]) * 4096 +
              longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
          if (v >= (1 << 20)) v -= (1 << 21);
        end
        7'h73: begin
          if (inst[14:12] >= 3'd5) begin
            e.typ = 3'd6;
            v = longint'(inst[19:15]);
          end else if (inst[14:12] != 3'd0 && inst[14:12] != 3'd4) begin
            e.typ = 3'd1;
            v = longint'(inst[31:20]);
            if (v >= 2048) v -= 4096;
          end
        end
        7'h33: ;
        default: e.ill = 1'b1;
      endcase
    end
    e.imm = 64'(v) & mask;
    e.tgt = tg ? ((pc + 64'(v)) & mask) : 64'd0;
    e.pc  = pc & mask;
    return e;
  endfunction

  task automatic check_outputs();
    chk("valid32", vld32, q32.size() > 0);
    chk("ready32", rdy32, q32.size() < 2);
    chk("valid64", vld64, q64.size() > 0);
    chk("ready64", rdy64, q64.size() < 2);
    if (q32.size() > 0) begin
      chk("imm32", imm32, q32[0].imm);
      chk("type32", typ32, q32[0].typ);
      chk("ill32", ill32, q32[0].ill);
      chk("tgt32", tgt32, q32[0].tgt);
      chk("pc32", opc32, q32[0].pc);
    end
    if (q64.size() > 0) begin
      chk("imm64", imm64, q64[0].imm);
      chk("type64", typ64, q64[0].typ);
      chk("ill64", ill64, q64[0].ill);
      chk("tgt64", tgt64, q64[0].tgt);
      chk("pc64", opc64, q64[0].pc);
    end
  endtask

  // One cycle: check what is presented now, drive inputs, advance the model
  // across the rising edge, return at the next falling edge.
  task automatic step(input bit iv, input logic [31:0] inst, input logic [63:0] pc,
                      input bit ordy, input bit fl);
    bit acc, pop;
    check_outputs();
    in_valid  = iv;
    in_inst   = inst;
    pc32      = pc[31:0];
    pc64      = pc;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (q32.size() < 2);
    pop = ordy && (q32.size() > 0);
    @(posedge clk);
    if (fl) begin
      q32.delete();
      q64.delete();
    end else begin
      if (pop) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (acc) begin
        q32.push_back(model(inst, pc, 32));
        q64.push_back(model(inst, pc, 64));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};

  initial begin
    logic [31:0] ri;
    int          r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; pc32 = '0; pc64 = '0;
    #1;
    chk("rst_valid", vld32, 1'b0);
    chk("rst_ready", rdy32, 1'b1);
    chk("rst_imm", imm32, 32'h0);
    chk("rst_type", typ64, 3'd0);
    chk("rst_tgt", tgt64, 64'h0);
    chk("rst_pc", opc64, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed decode vectors with literal expectations.
    step(1, 32'hFFF00093, 64'h0, 1, 0);
    chk("addi_valid", vld32, 1'b1);
    chk("addi_imm", imm32, 32'hFFFF_FFFF);
    chk("addi_type", typ32, 3'd1);
    chk("addi_ill", ill32, 1'b0);
    chk("addi_tgt", tgt32, 32'h0);
    step(1, 32'hFE000EE3, 64'h100, 1, 0);
    chk("beq_imm", imm32, 32'hFFFF_FFFC);
    chk("beq_type", typ32, 3'd3);
    chk("beq_tgt", tgt32, 32'h0000_00FC);
    step(1, 32'h001000EF, 64'h1000, 1, 0);
    chk("jal_imm", imm32, 32'h800);
    chk("jal_type", typ32, 3'd5);
    chk("jal_tgt", tgt32, 32'h1800);
    step(1, 32'h3002D073, 64'h0, 1, 0);
    chk("csrrwi_imm", imm32, 32'h5);
    chk("csrrwi_type", typ32, 3'd6);
    step(1, 32'h0000007F, 64'h0, 1, 0);
    chk("illeg_ill", ill32, 1'b1);
    chk("illeg_type", typ32, 3'd0);
    chk("illeg_imm", imm32, 32'h0);
    step(1, 32'h80000537, 64'h2000, 1, 0);
    chk("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui64_type", typ64, 3'd4);
    chk("lui64_tgt", tgt64, 64'h0);
    step(0, 32'h0, 64'h0, 1, 0);

    // Backpressure: A to main, B to skid, C refused until space frees.
    step(1, 32'h00500093, 64'h10, 0, 0);
    step(1, 32'h00600093, 64'h14, 0, 0);
    step(1, 32'h00700093, 64'h18, 0, 0);
    chk("bp_ready", rdy32, 1'b0);
    chk("bp_head", imm32, 32'h5);
    step(1, 32'h00700093, 64'h18, 0, 0);
    chk("bp_hold", imm32, 32'h5);
    step(1, 32'h00700093, 64'h18, 1, 0);
    chk("bp_second", imm32, 32'h6);
    step(1, 32'h00700093, 64'h18, 1, 0);
    chk("bp_third", imm32, 32'h7);
    step(0, 32'h0, 64'h0, 1, 0);
    step(0, 32'h0, 64'h0, 1, 0);

    // Flush with both buffers full and a new instruction offered.
    step(1, 32'h00100093, 64'h20, 0, 0);
    step(1, 32'h00200093, 64'h24, 0, 0);
    step(1, 32'h00300093, 64'h28, 0, 1);
    chk("flush_valid", vld32, 1'b0);
    chk("flush_ready", rdy64, 1'b1);
    step(0, 32'h0, 64'h0, 1, 0);
    step(0, 32'h0, 64'h0, 1, 0);

    // Asynchronous reset mid-stream.
    step(1, 32'h00100093, 64'h30, 0, 0);
    step(1, 32'h00200093, 64'h34, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_valid32", vld32, 1'b0);
    chk("arst_valid64", vld64, 1'b0);
    chk("arst_ready", rdy32, 1'b1);
    q32.delete();
    q64.delete();
    #1;
    rst = 1'b0;
    step(0, 32'h0, 64'h0, 1, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 12);
      ri = $urandom;
      if (r < 11) ri[6:0] = ops[r];
      step($urandom_range(0, 3) != 0, ri, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
